// File: rtl/ex_mem_register_pkg.sv
// ex_mem_register_pkg
// Shared definitions for the EX/MEM pipeline register:
//   - default widths for data, register index, PC and event counter
//   - exc_state_t : overflow-exception FSM states (RUN, EXC_PEND)
//   - ctrl_t      : MEM/WB control bundle carried down the pipe
package ex_mem_register_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_W_DEF  = 5;
  localparam int PC_W_DEF   = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_PEND = 1'b1
  } exc_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // A bubble carries no side effects: no register write, no memory access.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ovf_event_counter.sv
// ovf_event_counter
// Saturating event counter. It counts one per cycle with inc high and
// sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   clr   : synchronous clear (dominates inc)
//   inc   : count one event this cycle
//   count : current count
module ovf_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ex_mem_register.sv
// ex_mem_register
// EX/MEM pipeline register with precise signed-overflow exceptions.
// The ALU result, flags, store data and MEM/WB control bits are captured
// every non-stalled cycle. A trapping overflow turns its own slot into a
// bubble, latches the faulting PC and raises exc_req. Every younger slot is
// squashed until the controller answers with exc_ack.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   stall, flush                 : hold contents / insert a bubble
//   ex_valid, EXE_Result, EXE_Zero, Overflow, ex_ovf_trap,
//   ex_rt_data, ex_dest_reg, ex_pc, ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_mem_to_reg  : EX-stage slot and ALU outputs
//   exc_ack                      : controller has redirected fetch
//   mem_*                        : registered MEM-stage slot
//   exc_req, exc_epc             : pending overflow exception and its PC
//   ovf_count                    : saturating count of raised exceptions
module ex_mem_register
  import ex_mem_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] EXE_Result,
  input  logic              EXE_Zero,
  input  logic              Overflow,
  input  logic              ex_ovf_trap,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_rt_data,
  output logic              mem_zero,
  output logic [REG_W-1:0]  mem_dest_reg,
  output logic [PC_W-1:0]   mem_pc,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              exc_req,
  output logic [PC_W-1:0]   exc_epc,
  output logic [CNT_W-1:0]  ovf_count
);

  exc_state_t        state_reg;
  logic              mem_valid_reg;
  logic [DATA_W-1:0] mem_alu_result_reg;
  logic [DATA_W-1:0] mem_rt_data_reg;
  logic              mem_zero_reg;
  logic [REG_W-1:0]  mem_dest_reg_reg;
  logic [PC_W-1:0]   mem_pc_reg;
  ctrl_t             mem_ctrl_reg;
  logic              exc_req_reg;
  logic [PC_W-1:0]   exc_epc_reg;

  ctrl_t ex_ctrl;
  logic  trap;
  logic  squash;

  assign ex_ctrl = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};

  // A trap is only taken by an instruction that really enters MEM this
  // cycle. Stalled or flushed slots never enter MEM, and a second overflow
  // while one is pending belongs to an instruction that is squashed anyway.
  assign trap = (state_reg == RUN) && !stall && !flush &&
                ex_valid && ex_ovf_trap && Overflow;

  // The trapping instruction and everything younger until the ack is
  // turned into a bubble. The ack cycle's slot is included: it was fetched
  // before the redirect.
  assign squash = trap || (state_reg == EXC_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= RUN;
      exc_req_reg        <= 1'b0;
      exc_epc_reg        <= '0;
      mem_valid_reg      <= 1'b0;
      mem_alu_result_reg <= '0;
      mem_rt_data_reg    <= '0;
      mem_zero_reg       <= 1'b0;
      mem_dest_reg_reg   <= '0;
      mem_pc_reg         <= '0;
      mem_ctrl_reg       <= CTRL_BUBBLE;
    end else begin
      // Exception FSM. It keeps running while stalled, so an ack is never
      // lost.
      case (state_reg)
        RUN: begin
          if (trap) begin
            state_reg   <= EXC_PEND;
            exc_req_reg <= 1'b1;
            exc_epc_reg <= ex_pc;
          end
        end
        EXC_PEND: begin
          if (exc_ack) begin
            state_reg   <= RUN;
            exc_req_reg <= 1'b0;
          end
        end
        default: state_reg <= RUN;
      endcase

      // Slot update. flush beats stall, and stall beats load.
      if (flush || (!stall && squash)) begin
        mem_valid_reg      <= 1'b0;
        mem_alu_result_reg <= '0;
        mem_rt_data_reg    <= '0;
        mem_zero_reg       <= 1'b0;
        mem_dest_reg_reg   <= '0;
        mem_pc_reg         <= '0;
        mem_ctrl_reg       <= CTRL_BUBBLE;
      end else if (!stall) begin
        mem_valid_reg      <= ex_valid;
        mem_alu_result_reg <= EXE_Result;
        mem_rt_data_reg    <= ex_rt_data;
        mem_zero_reg       <= EXE_Zero;
        mem_dest_reg_reg   <= ex_dest_reg;
        mem_pc_reg         <= ex_pc;
        mem_ctrl_reg       <= ex_ctrl;
      end
    end
  end

  ovf_event_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_event_counter (
    .clk   (clk),
    .clr   (rst),
    .inc   (trap),
    .count (ovf_count)
  );

  assign mem_valid      = mem_valid_reg;
  assign mem_alu_result = mem_alu_result_reg;
  assign mem_rt_data    = mem_rt_data_reg;
  assign mem_zero       = mem_zero_reg;
  assign mem_dest_reg   = mem_dest_reg_reg;
  assign mem_pc         = mem_pc_reg;
  assign mem_reg_write  = mem_ctrl_reg.reg_write;
  assign mem_mem_read   = mem_ctrl_reg.mem_read;
  assign mem_mem_write  = mem_ctrl_reg.mem_write;
  assign mem_mem_to_reg = mem_ctrl_reg.mem_to_reg;
  assign exc_req        = exc_req_reg;
  assign exc_epc        = exc_epc_reg;

endmodule

// File: tb/tb_ex_mem_register.sv
// tb_ex_mem_register
// Directed vectors for ex_mem_register. Each vector pushes its
// hand-computed expected MEM-stage outputs, tagged with the clock edge that
// produces them, into a scoreboard queue. A separate monitor pops each
// entry once that edge has passed and compares it against the DUT. The
// counter width is reduced to 4 bits so saturation is reached in a few
// dozen cycles.
module tb_ex_mem_register;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, stall, flush, ex_valid, exe_zero, overflow, ex_ovf_trap;
  logic [DATA_W-1:0] exe_result, ex_rt_data;
  logic [REG_W-1:0]  ex_dest_reg;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, exc_ack;
  logic              mem_valid, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [DATA_W-1:0] mem_alu_result, mem_rt_data;
  logic [REG_W-1:0]  mem_dest_reg;
  logic [PC_W-1:0]   mem_pc;
  logic              exc_req;
  logic [PC_W-1:0]   exc_epc;
  logic [CNT_W-1:0]  ovf_count;

  ex_mem_register #(
    .DATA_W (DATA_W), .REG_W (REG_W), .PC_W (PC_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .stall (stall), .flush (flush),
    .ex_valid (ex_valid), .EXE_Result (exe_result), .EXE_Zero (exe_zero),
    .Overflow (overflow), .ex_ovf_trap (ex_ovf_trap), .ex_rt_data (ex_rt_data),
    .ex_dest_reg (ex_dest_reg), .ex_pc (ex_pc),
    .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read),
    .ex_mem_write (ex_mem_write), .ex_mem_to_reg (ex_mem_to_reg),
    .exc_ack (exc_ack),
    .mem_valid (mem_valid), .mem_alu_result (mem_alu_result),
    .mem_rt_data (mem_rt_data), .mem_zero (mem_zero),
    .mem_dest_reg (mem_dest_reg), .mem_pc (mem_pc),
    .mem_reg_write (mem_reg_write), .mem_mem_read (mem_mem_read),
    .mem_mem_write (mem_mem_write), .mem_mem_to_reg (mem_mem_to_reg),
    .exc_req (exc_req), .exc_epc (exc_epc), .ovf_count (ovf_count)
  );

  // Observed/expected MEM-stage view; ctrl = {reg_write, mem_read, mem_write, mem_to_reg}
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic              zero;
    logic [REG_W-1:0]  dest;
    logic [PC_W-1:0]   pc;
    logic [3:0]        ctrl;
    logic              req;
    logic [PC_W-1:0]   epc;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  typedef struct {
    obs_t  e;
    int    cyc;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  cycle_cnt = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic obs_t bub(input logic req, input logic [PC_W-1:0] epc,
                               input logic [CNT_W-1:0] cnt);
    obs_t o;
    o     = '0;
    o.req = req;
    o.epc = epc;
    o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t ld(input logic v, input logic [DATA_W-1:0] alu,
                              input logic [DATA_W-1:0] rt, input logic z,
                              input logic [REG_W-1:0] dest, input logic [PC_W-1:0] pc,
                              input logic [3:0] ctrl, input logic req,
                              input logic [PC_W-1:0] epc, input logic [CNT_W-1:0] cnt);
    obs_t o;
    o.valid = v;   o.alu = alu; o.rt  = rt;  o.zero = z;   o.dest = dest;
    o.pc    = pc;  o.ctrl = ctrl; o.req = req; o.epc = epc; o.cnt = cnt;
    return o;
  endfunction

  // Sets one EX-stage slot; stall, flush, ack and rst return to 0.
  task automatic set_in(input logic v, input logic [DATA_W-1:0] res,
                        input logic [DATA_W-1:0] rt, input logic z,
                        input logic [REG_W-1:0] dest, input logic [PC_W-1:0] pc,
                        input logic [3:0] ctrl, input logic ovf, input logic ten);
    ex_valid = v; exe_result = res; ex_rt_data = rt; exe_zero = z;
    ex_dest_reg = dest; ex_pc = pc; overflow = ovf; ex_ovf_trap = ten;
    {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = ctrl;
    stall = 1'b0; flush = 1'b0; exc_ack = 1'b0; rst = 1'b0;
  endtask

  // Queues the expectation for the coming edge, then advances past it.
  task automatic step(input obs_t e, input string name);
    sb_t t;
    t.e = e; t.cyc = cycle_cnt + 1; t.name = name;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every entry whose capturing edge has passed.
  initial begin
    sb_t  t;
    obs_t act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
        t   = sb_q.pop_front();
        act = {mem_valid, mem_alu_result, mem_rt_data, mem_zero, mem_dest_reg, mem_pc,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               exc_req, exc_epc, ovf_count};
        n_cmp = n_cmp + 1;
        if (act !== t.e) begin
          n_bad = n_bad + 1;
          $display("FAIL txn %0d %s: got %h required %h", n_cmp, t.name, act, t.e);
        end else begin
          $display("txn %0d %s ok: valid=%b req=%b epc=%h cnt=%h", n_cmp, t.name,
                   act.valid, act.req, act.epc, act.cnt);
        end
      end
    end
  end

  initial begin
    obs_t             e;
    logic [PC_W-1:0]  p;
    logic [CNT_W-1:0] c;

    set_in(1'b0, '0, '0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    step(bub(1'b0, '0, '0), "reset");

    // Plain captures
    set_in(1'b1, 64'h1234, 64'hAAAA, 1'b0, 5'd5, 32'h10, 4'b1000, 1'b0, 1'b0);
    step(ld(1'b1, 64'h1234, 64'hAAAA, 1'b0, 5'd5, 32'h10, 4'b1000, 1'b0, '0, '0), "plain_load");
    set_in(1'b1, 64'h0, 64'hDEADBEEF, 1'b1, 5'd0, 32'h14, 4'b0010, 1'b0, 1'b0);
    step(ld(1'b1, 64'h0, 64'hDEADBEEF, 1'b1, 5'd0, 32'h14, 4'b0010, 1'b0, '0, '0), "store_zero");
    set_in(1'b0, 64'h77, 64'h88, 1'b0, 5'd7, 32'h18, 4'b0000, 1'b0, 1'b0);
    step(ld(1'b0, 64'h77, 64'h88, 1'b0, 5'd7, 32'h18, 4'b0000, 1'b0, '0, '0), "invalid_slot");

    // Overflow on an unsigned op passes through
    set_in(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 5'd3, 32'h1C, 4'b1000, 1'b1, 1'b0);
    e = ld(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 5'd3, 32'h1C, 4'b1000, 1'b0, '0, '0);
    step(e, "unsigned_ovf");

    // Stall freezes the slot; the last stalled cycle carries a would-be trap
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i), i[0], 5'd9, 32'h60 + 32'(4 * i),
             4'b1101, (i == 2), (i == 2));
      stall = 1'b1;
      step(e, "stall_hold");
    end

    // Flush wins over stall and suppresses the trap
    set_in(1'b1, 64'h300, 64'h301, 1'b0, 5'd10, 32'h70, 4'b1000, 1'b1, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    step(bub(1'b0, '0, '0), "flush_trap");

    set_in(1'b1, 64'h55, 64'h66, 1'b0, 5'd2, 32'h20, 4'b1001, 1'b0, 1'b0);
    step(ld(1'b1, 64'h55, 64'h66, 1'b0, 5'd2, 32'h20, 4'b1001, 1'b0, '0, '0), "reload");

    // Trap, squash younger slots, ignore a second overflow, then ack
    set_in(1'b1, 64'hFFFF, 64'h1, 1'b0, 5'd4, 32'h40, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h40, 4'd1), "trap");
    set_in(1'b1, 64'h11, 64'h0, 1'b0, 5'd6, 32'h44, 4'b1000, 1'b0, 1'b0);
    step(bub(1'b1, 32'h40, 4'd1), "squash");
    set_in(1'b1, 64'h12, 64'h0, 1'b0, 5'd6, 32'h48, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h40, 4'd1), "retrap_ignored");
    set_in(1'b1, 64'h13, 64'h0, 1'b0, 5'd6, 32'h4C, 4'b1000, 1'b0, 1'b0);
    exc_ack = 1'b1;
    step(bub(1'b0, 32'h40, 4'd1), "ack");
    set_in(1'b1, 64'h14, 64'h15, 1'b0, 5'd8, 32'h50, 4'b0100, 1'b0, 1'b0);
    exc_ack = 1'b1;
    step(ld(1'b1, 64'h14, 64'h15, 1'b0, 5'd8, 32'h50, 4'b0100, 1'b0, 32'h40, 4'd1), "ack_in_run");

    // Ack during a stall still leaves EXC_PEND
    set_in(1'b1, 64'h21, 64'h0, 1'b0, 5'd1, 32'h80, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h80, 4'd2), "trap2");
    set_in(1'b1, 64'h22, 64'h0, 1'b0, 5'd1, 32'h84, 4'b1000, 1'b0, 1'b0);
    stall   = 1'b1;
    exc_ack = 1'b1;
    step(bub(1'b0, 32'h80, 4'd2), "ack_stalled");
    set_in(1'b1, 64'h23, 64'h24, 1'b0, 5'd1, 32'h88, 4'b1010, 1'b0, 1'b0);
    step(ld(1'b1, 64'h23, 64'h24, 1'b0, 5'd1, 32'h88, 4'b1010, 1'b0, 32'h80, 4'd2), "resume");

    // Flush while pending leaves the exception in place
    set_in(1'b1, 64'h31, 64'h0, 1'b0, 5'd1, 32'h90, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h90, 4'd3), "trap3");
    set_in(1'b1, 64'h32, 64'h0, 1'b0, 5'd1, 32'h94, 4'b1000, 1'b0, 1'b0);
    flush = 1'b1;
    step(bub(1'b1, 32'h90, 4'd3), "flush_pend");
    set_in(1'b0, 64'h0, 64'h0, 1'b0, 5'd0, 32'h98, 4'b0000, 1'b0, 1'b0);
    exc_ack = 1'b1;
    step(bub(1'b0, 32'h90, 4'd3), "ack3");

    // Drive the counter into saturation
    c = 4'd3;
    for (int i = 0; i < 14; i++) begin
      p = 32'h100 + 32'(4 * i);
      if (c != 4'hF) c = c + 4'd1;
      set_in(1'b1, 64'h1, 64'h0, 1'b0, 5'd1, p, 4'b1000, 1'b1, 1'b1);
      step(bub(1'b1, p, c), "sat_trap");
      set_in(1'b0, 64'h0, 64'h0, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);
      exc_ack = 1'b1;
      step(bub(1'b0, p, c), "sat_ack");
    end
    set_in(1'b1, 64'h1, 64'h0, 1'b0, 5'd1, 32'h200, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h200, 4'hF), "sat_hold");

    // Reset while pending discards the exception and the count
    set_in(1'b1, 64'h41, 64'h42, 1'b1, 5'd3, 32'h204, 4'b1111, 1'b0, 1'b0);
    rst = 1'b1;
    step(bub(1'b0, '0, '0), "rst_in_pend");
    set_in(1'b1, 64'h51, 64'h52, 1'b0, 5'd3, 32'h208, 4'b1001, 1'b0, 1'b0);
    step(ld(1'b1, 64'h51, 64'h52, 1'b0, 5'd3, 32'h208, 4'b1001, 1'b0, '0, '0), "post_rst_load");
    set_in(1'b1, 64'h61, 64'h0, 1'b0, 5'd3, 32'h20C, 4'b1000, 1'b1, 1'b1);
    step(bub(1'b1, 32'h20C, 4'd1), "post_rst_trap");
    set_in(1'b0, 64'h0, 64'h0, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_register.md
# ex_mem_register

EX/MEM pipeline register of the MIPS pipeline, directly downstream of the combinational ALU. Captures the ALU result, zero and overflow flags, store data and MEM/WB control bits each cycle. Applies stall/flush and converts a signed-arithmetic overflow into a precise exception request. The trapping instruction is squashed and younger instructions are blocked until the hazard/exception controller acknowledges.

## Interface
- DATA_W, 64, ALU result / store-data width
- REG_W, 5, destination register index width
- PC_W, 32, program counter width
- CNT_W, 16, overflow-event counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all EX/MEM contents (MEM not ready)
- flush  in  1  replace the captured slot with a bubble
- ex_valid  in  1  EX slot holds a real instruction
- EXE_Result  in  DATA_W  ALU result
- EXE_Zero  in  1  ALU zero flag
- Overflow  in  1  ALU overflow flag
- ex_ovf_trap  in  1  instruction traps on overflow (add/sub signed)
- ex_rt_data  in  DATA_W  forwarded rt value (store data)
- ex_dest_reg  in  REG_W  writeback register index
- ex_pc  in  PC_W  instruction PC
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  control bits
- exc_ack  in  1  controller has redirected fetch
- mem_valid  out  1
- mem_alu_result, mem_rt_data  out  DATA_W
- mem_zero  out  1
- mem_dest_reg  out  REG_W
- mem_pc  out  PC_W
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each
- exc_req  out  1  overflow exception pending
- exc_epc  out  PC_W  PC of the trapping instruction
- ovf_count  out  CNT_W  saturating count of raised exceptions

## Operation
- FSM states: RUN, EXC_PEND.
- Per-cycle priority: rst > flush > stall > load.
- Bubble: mem_valid and all four control outputs are 0. Data outputs are don't-care, but the implementation zeroes them.
- Trap condition: state RUN, not stall, not flush, ex_valid, ex_ovf_trap and Overflow all true.
- RUN, load without trap: all mem_* outputs take the ex_* / ALU inputs; mem_valid = ex_valid.
- RUN, load with trap:
  - slot becomes a bubble (no register write, no memory access);
  - exc_epc <= ex_pc and exc_req <= 1;
  - ovf_count increments, saturating at all-ones;
  - state moves to EXC_PEND.
- EXC_PEND:
  - every non-stalled load is forced to a bubble, so younger instructions are squashed;
  - exc_req stays 1 and exc_epc is held;
  - a second overflow does not re-trap or count;
  - exc_ack = 1 sets exc_req <= 0 and returns state to RUN. The same cycle's load is still a bubble.
- exc_ack in RUN is ignored.
- Flush in either state: captured slot is a bubble; FSM and exc_* are unchanged.
- Stall: all mem_* outputs hold; the FSM transition on exc_ack still occurs; no trap is detected on a stalled cycle.
- Overflow with ex_ovf_trap = 0 (unsigned ops) passes through silently.

## Timing
- Latency is 1 cycle, input to mem_* outputs.
- exc_req rises the cycle after the trapping instruction is captured and falls the cycle after exc_ack.
- Reset values:
  - all mem_* outputs 0;
  - exc_req 0, exc_epc 0, ovf_count 0;
  - state RUN.
- Reset during EXC_PEND discards the pending exception.
- ovf_count wraps never: at 0xFFFF it stays 0xFFFF.

## Structure
- Shared pipeline package holds:
  - state enum (RUN, EXC_PEND);
  - the ctrl bundle (reg_write, mem_read, mem_write, mem_to_reg);
  - DATA_W, REG_W, PC_W defaults.
- One sub-module: ovf_event_counter, a CNT_W saturating counter with inc and synchronous clear.
- Remaining logic (register bank and FSM) stays in ex_mem_register.

## Test plan
- Plain load: EXE_Result=64'h1234, ex_dest_reg=5, ex_reg_write=1, ex_valid=1 -> next cycle mem_alu_result=64'h1234, mem_dest_reg=5, mem_reg_write=1, mem_valid=1, exc_req=0.
- Overflow trap: ex_pc=32'h40, ex_ovf_trap=1, Overflow=1 ->
  - next cycle mem_valid=0, mem_reg_write=0, exc_req=1, exc_epc=32'h40, ovf_count=1;
  - following valid instructions yield bubbles until exc_ack;
  - exc_req=0 one cycle after exc_ack.
- Stall/flush: stall=1 for 3 cycles with changing inputs -> mem_* frozen. flush=1 together with stall=1 and a trapping overflow -> bubble, exc_req stays 0, ovf_count unchanged.
- Untrapped overflow: Overflow=1, ex_ovf_trap=0, ex_reg_write=1 -> normal capture, exc_req=0.
- Saturation and reset: preset ovf_count to 16'hFFFF via a trap sequence -> another trap leaves it at 16'hFFFF. Assert rst during EXC_PEND -> next cycle exc_req=0, state RUN, all outputs 0.
